// File: rtl/pipeline_pkg.sv
// Shared pipeline types and constants for the RV64I hazard controller.
package pipeline_pkg;

   typedef enum logic [1:0] {
      FWD_RF = 2'b00,
      FWD_W  = 2'b01,
      FWD_M  = 2'b10
   } fwd_sel_e;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } hazard_state_e;

   localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
   localparam logic [4:0] REG_X0          = 5'd0;

   // M-stage producer wins over W-stage producer; x0 never forwards.
   function automatic fwd_sel_e fwd_sel(
      input logic [4:0] rs,
      input logic [4:0] rd_m,
      input logic       we_m,
      input logic [4:0] rd_w,
      input logic       we_w
   );
      if (we_m && rd_m != REG_X0 && rd_m == rs)
         return FWD_M;
      else if (we_w && rd_w != REG_X0 && rd_w == rs)
         return FWD_W;
      else
         return FWD_RF;
   endfunction

endpackage

// File: rtl/hazard_perf_cnt.sv
// Single saturating event counter with enable and synchronous clear.
module hazard_perf_cnt #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_cnt
);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (i_clr)
         r_cnt <= '0;
      else if (i_en && r_cnt != '1)
         r_cnt <= r_cnt + 1'b1;
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller: stalls, flushes, forwarding, memory-wait FSM.
// Optional perf counters are built when HAZARD_PERF_EN is defined.
module hazard_ctrl
   import pipeline_pkg::*;
#(
   parameter int MEM_TIMEOUT = 255,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       Rs1_D,
   input  logic [4:0]       Rs2_D,
   input  logic [4:0]       Rs1_E,
   input  logic [4:0]       Rs2_E,
   input  logic [4:0]       Rd_E,
   input  logic [4:0]       Rd_M,
   input  logic [4:0]       Rd_W,
   input  logic             RegWrite_M,
   input  logic             RegWrite_W,
   input  logic [1:0]       ResultSrc_E,
   input  logic             PCSrc_E,
   input  logic             MemReq_M,
   input  logic             mem_ready,
   output logic             Stall_F,
   output logic             Stall_D,
   output logic             Stall_E,
   output logic             Stall_M,
   output logic             Flush_D,
   output logic             Flush_E,
   output logic             Flush_W,
   output logic [1:0]       ForwardA_E,
   output logic [1:0]       ForwardB_E,
   output logic             PCRedirect_F,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] ld_use_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic [CNT_W-1:0] mem_wait_cnt
);

   localparam logic [7:0] LP_TO = 8'(MEM_TIMEOUT);

   hazard_state_e r_state;
   hazard_state_e w_state_nxt;
   logic [7:0]    r_wait;
   logic [7:0]    w_wait_inc;
   logic          r_err;
   logic          w_mem_stall;
   logic          w_ld_use;
   logic          w_ld_use_app;

   assign w_mem_stall = MemReq_M && !mem_ready;
   assign w_ld_use    = ResultSrc_E == RESULT_SRC_LOAD
                     && Rd_E != REG_X0
                     && (Rd_E == Rs1_D || Rd_E == Rs2_D);

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= RUN;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         RUN:      if (w_mem_stall) w_state_nxt = MEM_WAIT;
         MEM_WAIT: if (mem_ready || !MemReq_M) w_state_nxt = RUN;
         default:  w_state_nxt = RUN;
      endcase
   end

   // Hazard outputs are zero-latency; the FSM only tracks wait duration.
   always_comb begin
      Stall_F      = 1'b0;
      Stall_D      = 1'b0;
      Stall_E      = 1'b0;
      Stall_M      = 1'b0;
      Flush_D      = 1'b0;
      Flush_E      = 1'b0;
      Flush_W      = 1'b0;
      PCRedirect_F = 1'b0;
      w_ld_use_app = 1'b0;
      ForwardA_E   = FWD_RF;
      ForwardB_E   = FWD_RF;
      if (rst) begin
         Flush_D = 1'b1;
         Flush_E = 1'b1;
         Flush_W = 1'b1;
      end else begin
         ForwardA_E = fwd_sel(Rs1_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
         ForwardB_E = fwd_sel(Rs2_E, Rd_M, RegWrite_M, Rd_W, RegWrite_W);
         if (w_mem_stall) begin
            Stall_F = 1'b1;
            Stall_D = 1'b1;
            Stall_E = 1'b1;
            Stall_M = 1'b1;
            Flush_W = 1'b1;
         end else if (PCSrc_E) begin
            PCRedirect_F = 1'b1;
            Flush_D      = 1'b1;
            Flush_E      = 1'b1;
         end else if (w_ld_use) begin
            Stall_F      = 1'b1;
            Stall_D      = 1'b1;
            Flush_E      = 1'b1;
            w_ld_use_app = 1'b1;
         end
      end
   end

   assign w_wait_inc = (r_wait == 8'hFF) ? r_wait : r_wait + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wait <= 8'd0;
         r_err  <= 1'b0;
      end else begin
         r_wait <= (r_state == RUN) ? 8'd0 : w_wait_inc;
         if (r_state == MEM_WAIT && w_wait_inc >= LP_TO)
            r_err <= 1'b1;
      end
   end

   assign mem_timeout_err = r_err;

`ifdef HAZARD_PERF_EN
   hazard_perf_cnt #(.W(CNT_W)) u_ld_use_cnt (
      .clk   (clk),
      .i_clr (rst),
      .i_en  (w_ld_use_app),
      .o_cnt (ld_use_cnt)
   );

   hazard_perf_cnt #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .i_clr (rst),
      .i_en  (PCRedirect_F),
      .o_cnt (flush_cnt)
   );

   hazard_perf_cnt #(.W(CNT_W)) u_mem_wait_cnt (
      .clk   (clk),
      .i_clr (rst),
      .i_en  (w_mem_stall),
      .o_cnt (mem_wait_cnt)
   );
`else
   assign ld_use_cnt   = '0;
   assign flush_cnt    = '0;
   assign mem_wait_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: vector table plus multi-cycle sequences.
module tb_hazard_ctrl;

   localparam int CNT_W = 32;
`ifdef HAZARD_PERF_EN
   localparam bit PERF = 1'b1;
`else
   localparam bit PERF = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   logic [4:0] Rs1_D, Rs2_D, Rs1_E, Rs2_E, Rd_E, Rd_M, Rd_W;
   logic RegWrite_M, RegWrite_W;
   logic [1:0] ResultSrc_E;
   logic PCSrc_E, MemReq_M, mem_ready;
   logic Stall_F, Stall_D, Stall_E, Stall_M;
   logic Flush_D, Flush_E, Flush_W;
   logic [1:0] ForwardA_E, ForwardB_E;
   logic PCRedirect_F, mem_timeout_err;
   logic [CNT_W-1:0] ld_use_cnt, flush_cnt, mem_wait_cnt;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .Rs1_D(Rs1_D), .Rs2_D(Rs2_D),
      .Rs1_E(Rs1_E), .Rs2_E(Rs2_E), .Rd_E(Rd_E),
      .Rd_M(Rd_M), .Rd_W(Rd_W),
      .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
      .ResultSrc_E(ResultSrc_E), .PCSrc_E(PCSrc_E),
      .MemReq_M(MemReq_M), .mem_ready(mem_ready),
      .Stall_F(Stall_F), .Stall_D(Stall_D),
      .Stall_E(Stall_E), .Stall_M(Stall_M),
      .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
      .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
      .PCRedirect_F(PCRedirect_F),
      .mem_timeout_err(mem_timeout_err),
      .ld_use_cnt(ld_use_cnt), .flush_cnt(flush_cnt),
      .mem_wait_cnt(mem_wait_cnt)
   );

   typedef struct {
      logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
      logic       rwm, rww;
      logic [1:0] rsrc;
      logic       pcs, mreq, rdy;
      logic [3:0] xst;
      logic [2:0] xfl;
      logic       xred;
      logic [1:0] xfa, xfb;
   } vec_t;

   vec_t v[13];

   function automatic int pexp(input int n);
      return PERF ? n : 0;
   endfunction

   task automatic chk(input string name, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", name, got, exp);
      end
   endtask

   task automatic idle();
      Rs1_D = 0; Rs2_D = 0; Rs1_E = 0; Rs2_E = 0;
      Rd_E = 0; Rd_M = 0; Rd_W = 0;
      RegWrite_M = 0; RegWrite_W = 0;
      ResultSrc_E = 2'b00; PCSrc_E = 0;
      MemReq_M = 0; mem_ready = 1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_ctl(input string n, input logic [3:0] st,
                            input logic [2:0] fl, input logic red);
      @(negedge clk);
      chk({n, " stall"}, 32'({Stall_F, Stall_D, Stall_E, Stall_M}), 32'(st));
      chk({n, " flush"}, 32'({Flush_D, Flush_E, Flush_W}), 32'(fl));
      chk({n, " redir"}, 32'(PCRedirect_F), 32'(red));
   endtask

   task automatic do_reset();
      step();
      rst = 1;
      idle();
      step();
      rst = 0;
   endtask

   initial begin
      //       rs1d rs2d rs1e rs2e rde rdm rdw rwm rww rsrc pcs mreq rdy st fl red fa fb
      v[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 1, 1, 2'b00, 0, 0, 1,
                4'b0000, 3'b000, 0, 2'b10, 2'b00};
      v[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 0, 1, 2'b00, 0, 0, 1,
                4'b0000, 3'b000, 0, 2'b01, 2'b00};
      v[2]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 1, 1, 2'b00, 0, 0, 1,
                4'b0000, 3'b000, 0, 2'b00, 2'b00};
      v[3]  = '{5'd0, 5'd0, 5'd3, 5'd9, 5'd0, 5'd3, 5'd9, 1, 1, 2'b00, 0, 0, 1,
                4'b0000, 3'b000, 0, 2'b10, 2'b01};
      v[4]  = '{5'd0, 5'd0, 5'd0, 5'd6, 5'd0, 5'd0, 5'd6, 1, 1, 2'b00, 0, 0, 1,
                4'b0000, 3'b000, 0, 2'b00, 2'b01};
      v[5]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 2'b01, 0, 0, 1,
                4'b1100, 3'b010, 0, 2'b00, 2'b00};
      v[6]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 2'b01, 0, 0, 1,
                4'b1100, 3'b010, 0, 2'b00, 2'b00};
      v[7]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 2'b00, 0, 0, 1,
                4'b0000, 3'b000, 0, 2'b00, 2'b00};
      v[8]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b01, 0, 0, 1,
                4'b0000, 3'b000, 0, 2'b00, 2'b00};
      v[9]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 2'b01, 1, 0, 1,
                4'b0000, 3'b110, 1, 2'b00, 2'b00};
      v[10] = '{5'd0, 5'd7, 5'd5, 5'd0, 5'd7, 5'd5, 5'd0, 1, 0, 2'b01, 1, 1, 0,
                4'b1111, 3'b001, 0, 2'b10, 2'b00};
      v[11] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 0, 0, 2'b00, 1, 1, 1,
                4'b0000, 3'b110, 1, 2'b00, 2'b00};
      v[12] = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 0, 0, 2'b10, 0, 0, 0,
                4'b0000, 3'b000, 0, 2'b00, 2'b00};

      rst = 1;
      idle();
      // Reset: hazardous inputs present, outputs must be forced.
      Rs1_E = 5; Rd_M = 5; RegWrite_M = 1;
      ResultSrc_E = 2'b01; Rd_E = 7; Rs2_D = 7;
      PCSrc_E = 1; MemReq_M = 1; mem_ready = 0;
      check_ctl("rst", 4'b0000, 3'b111, 1'b0);
      chk("rst fwdA", 32'(ForwardA_E), 32'd0);
      step();
      rst = 0;
      idle();
      @(negedge clk);
      chk("rst err", 32'(mem_timeout_err), 32'd0);
      chk("rst ldcnt", ld_use_cnt, 32'd0);
      chk("rst mwcnt", mem_wait_cnt, 32'd0);

      for (int i = 0; i < 13; i++) begin
         step();
         Rs1_D = v[i].rs1d; Rs2_D = v[i].rs2d;
         Rs1_E = v[i].rs1e; Rs2_E = v[i].rs2e;
         Rd_E = v[i].rde; Rd_M = v[i].rdm; Rd_W = v[i].rdw;
         RegWrite_M = v[i].rwm; RegWrite_W = v[i].rww;
         ResultSrc_E = v[i].rsrc; PCSrc_E = v[i].pcs;
         MemReq_M = v[i].mreq; mem_ready = v[i].rdy;
         check_ctl($sformatf("v%0d", i), v[i].xst, v[i].xfl, v[i].xred);
         chk($sformatf("v%0d fwdA", i), 32'(ForwardA_E), 32'(v[i].xfa));
         chk($sformatf("v%0d fwdB", i), 32'(ForwardB_E), 32'(v[i].xfb));
      end

      // One-cycle load-use produces exactly one bubble.
      do_reset();
      ResultSrc_E = 2'b01; Rd_E = 7; Rs2_D = 7;
      check_ctl("lu c0", 4'b1100, 3'b010, 1'b0);
      step();
      idle();
      check_ctl("lu c1", 4'b0000, 3'b000, 1'b0);
      chk("lu cnt", ld_use_cnt, 32'(pexp(1)));

      // Three-cycle memory wait with forwarding kept live.
      do_reset();
      for (int c = 0; c < 3; c++) begin
         MemReq_M = 1; mem_ready = 0;
         Rs2_E = 4; Rd_W = 4; RegWrite_W = 1;
         check_ctl($sformatf("mw c%0d", c), 4'b1111, 3'b001, 1'b0);
         chk($sformatf("mw c%0d fwdB", c), 32'(ForwardB_E), 32'd1);
         step();
      end
      mem_ready = 1;
      check_ctl("mw c3", 4'b0000, 3'b000, 1'b0);
      step();
      idle();
      @(negedge clk);
      chk("mw cnt", mem_wait_cnt, 32'(pexp(3)));
      chk("mw err", 32'(mem_timeout_err), 32'd0);

      // Branch held through a two-cycle wait fires on release.
      do_reset();
      for (int c = 0; c < 2; c++) begin
         PCSrc_E = 1; MemReq_M = 1; mem_ready = 0;
         check_ctl($sformatf("bw c%0d", c), 4'b1111, 3'b001, 1'b0);
         step();
      end
      mem_ready = 1;
      check_ctl("bw rel", 4'b0000, 3'b110, 1'b1);
      step();
      idle();
      @(negedge clk);
      chk("bw fcnt", flush_cnt, 32'(pexp(1)));
      chk("bw mwcnt", mem_wait_cnt, 32'(pexp(2)));

      // Timeout at 4 wait cycles: cycle 0 is RUN, cycles 1..4 MEM_WAIT.
      do_reset();
      MemReq_M = 1; mem_ready = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk($sformatf("to c%0d err", c), 32'(mem_timeout_err),
             (c >= 5) ? 32'd1 : 32'd0);
         chk($sformatf("to c%0d stF", c), 32'(Stall_F), 32'd1);
         step();
      end
      idle();
      step();
      step();
      @(negedge clk);
      chk("to sticky", 32'(mem_timeout_err), 32'd1);
      MemReq_M = 1; mem_ready = 0;
      step();
      step();
      rst = 1;
      check_ctl("to rst", 4'b0000, 3'b111, 1'b0);
      step();
      rst = 0;
      idle();
      @(negedge clk);
      chk("to clr", 32'(mem_timeout_err), 32'd0);
      // Counter must restart from zero: four stall cycles stay below limit.
      MemReq_M = 1; mem_ready = 0;
      for (int c = 0; c < 4; c++) step();
      @(negedge clk);
      chk("to restart", 32'(mem_timeout_err), 32'd0);
      step();
      @(negedge clk);
      chk("to again", 32'(mem_timeout_err), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
